vga_char_timing: RTL and testbench

- Produces the scan side of the character display. It generates 640x480@60 VGA horizontal and vertical counters.
- It drives the character-coordinate bus (char_column, char_line, subchar_line, subchar_pixel) into the character display block and receives that block's per-pixel colour bits back.
- It re-aligns those colour bits with hsync, vsync and blanking through a latency-matched pipeline, then outputs the registered VGA signals to the pins.
- Sits between the pixel clock source and the board VGA connector.

---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/vga_char_timing_if.sv | 22 ++
 rtl/vga_delay_pipe.sv | 37 +++
 rtl/vga_char_timing.sv | 142 ++++++++++++++
 tb/tb_vga_char_timing.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, character-cell geometry and the
// scan status bundle carried through the colour-alignment pipe.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int PIPE_LAT          = 2;
  localparam logic SYNC_ACTIVE     = 1'b0;

  localparam int CNT_W     = 10;
  localparam int CELL      = 8;
  localparam int CELL_BITS = 3;
  localparam int COORD_W   = CNT_W - CELL_BITS;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic fs;
  } scan_status_t;

  localparam scan_status_t STATUS_IDLE = '{active: 1'b0, hs: 1'b0, vs: 1'b0, fs: 1'b0};

  function automatic logic in_window(input int pos, input int lo, input int len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage

// File: rtl/vga_char_timing_if.sv
// Character-coordinate bus to the display block and its returned colour bits.
interface vga_char_timing_if;
  import vga_timing_pkg::*;

  logic [COORD_W-1:0]   char_column;
  logic [COORD_W-1:0]   char_line;
  logic [CELL_BITS-1:0] subchar_line;
  logic [CELL_BITS-1:0] subchar_pixel;
  logic                 vga_red_data;
  logic                 vga_green_data;
  logic                 vga_blue_data;

  modport master (
    output char_column, char_line, subchar_line, subchar_pixel,
    input  vga_red_data, vga_green_data, vga_blue_data
  );

  modport slave (
    input  char_column, char_line, subchar_line, subchar_pixel,
    output vga_red_data, vga_green_data, vga_blue_data
  );
endinterface

// File: rtl/vga_delay_pipe.sv
// WIDTH x DEPTH shift register; every stage loads rst_val on synchronous reset.
module vga_delay_pipe #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= rst_val;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_char_timing.sv
// VGA scan timing: free-running counters, character coordinates to the display
// block, and registered colour re-aligned with sync/blanking at the pins.
module vga_char_timing #(
  parameter int   H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
  parameter int   H_FP        = vga_timing_pkg::H_FP,
  parameter int   H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int   H_BP        = vga_timing_pkg::H_BP,
  parameter int   V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
  parameter int   V_FP        = vga_timing_pkg::V_FP,
  parameter int   V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int   V_BP        = vga_timing_pkg::V_BP,
  parameter int   PIPE_LAT    = vga_timing_pkg::PIPE_LAT,
  parameter logic SYNC_ACTIVE = vga_timing_pkg::SYNC_ACTIVE
) (
  input  logic              pixel_clock,
  input  logic              reset,
  vga_char_timing_if.master disp,
  output logic              vga_red,
  output logic              vga_green,
  output logic              vga_blue,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              video_active,
  output logic              frame_start
);
  import vga_timing_pkg::*;

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [CNT_W-1:0]     h_count_q, h_count_d;
  logic [CNT_W-1:0]     v_count_q, v_count_d;
  logic                 h_wrap_s;
  logic [COORD_W-1:0]   col_q, col_d, row_q, row_d;
  logic [CELL_BITS-1:0] spx_q, spx_d, sln_q, sln_d;
  scan_status_t         st0_q, st0_d, st_dly_s;
  logic                 red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic                 hsync_q, hsync_d, vsync_q, vsync_d;
  logic                 active_q, active_d, fs_q, fs_d;

  // v_count only advances on the h_count wrap, so vsync edges fall on line boundaries
  always_comb begin
    h_wrap_s  = (int'(h_count_q) == H_TOT - 1);
    h_count_d = h_count_q + 1'b1;
    v_count_d = v_count_q;
    if (h_wrap_s) begin
      h_count_d = '0;
      if (int'(v_count_q) == V_TOT - 1) begin
        v_count_d = '0;
      end else begin
        v_count_d = v_count_q + 1'b1;
      end
    end else begin
      v_count_d = v_count_q;
    end

    col_d = h_count_q[CNT_W-1:CELL_BITS];
    spx_d = h_count_q[CELL_BITS-1:0];
    row_d = v_count_q[CNT_W-1:CELL_BITS];
    sln_d = v_count_q[CELL_BITS-1:0];

    st0_d.active = (int'(h_count_q) < H_ACTIVE) && (int'(v_count_q) < V_ACTIVE);
    st0_d.hs     = in_window(int'(h_count_q), H_ACTIVE + H_FP, H_SYNC);
    st0_d.vs     = in_window(int'(v_count_q), V_ACTIVE + V_FP, V_SYNC);
    st0_d.fs     = (h_count_q == '0) && (v_count_q == '0);
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      h_count_q <= '0;
      v_count_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      spx_q     <= '0;
      sln_q     <= '0;
      st0_q     <= STATUS_IDLE;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
      col_q     <= col_d;
      row_q     <= row_d;
      spx_q     <= spx_d;
      sln_q     <= sln_d;
      st0_q     <= st0_d;
    end
  end

  // Status emerges from the pipe in the same cycle the display returns its colour
  vga_delay_pipe #(
    .WIDTH ($bits(scan_status_t)),
    .DEPTH (PIPE_LAT)
  ) u_status_pipe (
    .clk     (pixel_clock),
    .rst     (reset),
    .rst_val (STATUS_IDLE),
    .din     (st0_q),
    .dout    (st_dly_s)
  );

  always_comb begin
    red_d    = disp.vga_red_data   & st_dly_s.active;
    green_d  = disp.vga_green_data & st_dly_s.active;
    blue_d   = disp.vga_blue_data  & st_dly_s.active;
    hsync_d  = st_dly_s.hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d  = st_dly_s.vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    active_d = st_dly_s.active;
    fs_d     = st_dly_s.fs;
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      red_q    <= 1'b0;
      green_q  <= 1'b0;
      blue_q   <= 1'b0;
      hsync_q  <= ~SYNC_ACTIVE;
      vsync_q  <= ~SYNC_ACTIVE;
      active_q <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      fs_q     <= fs_d;
    end
  end

  assign disp.char_column   = col_q;
  assign disp.char_line     = row_q;
  assign disp.subchar_pixel = spx_q;
  assign disp.subchar_line  = sln_q;
  assign vga_red            = red_q;
  assign vga_green          = green_q;
  assign vga_blue           = blue_q;
  assign vga_hsync          = hsync_q;
  assign vga_vsync          = vsync_q;
  assign video_active       = active_q;
  assign frame_start        = fs_q;

endmodule

// File: tb/tb_vga_char_timing.sv
// Bench: full-size 640x480 timing plus a shrunken, inverted-sync instance whose
// frames are short enough to exercise vertical blanking, vsync and frame wrap.
module tb_vga_char_timing;
  import vga_timing_pkg::*;

  localparam int LAT = PIPE_LAT + 2;
  localparam int HA  [2] = '{640, 24};
  localparam int HFP [2] = '{16, 4};
  localparam int HSW [2] = '{96, 8};
  localparam int HBP [2] = '{48, 4};
  localparam int VA  [2] = '{480, 16};
  localparam int VFP [2] = '{10, 2};
  localparam int VSW [2] = '{2, 2};
  localparam int VBP [2] = '{33, 3};
  localparam logic SPOL [2] = '{1'b0, 1'b1};

  logic pixel_clock;
  logic reset;
  logic red_a, green_a, blue_a, hs_a, vs_a, act_a, fs_a;
  logic red_b, green_b, blue_b, hs_b, vs_b, act_b, fs_b;

  vga_char_timing_if bus_a ();
  vga_char_timing_if bus_b ();

  vga_char_timing u_dut_a (
    .pixel_clock (pixel_clock), .reset (reset), .disp (bus_a),
    .vga_red (red_a), .vga_green (green_a), .vga_blue (blue_a),
    .vga_hsync (hs_a), .vga_vsync (vs_a),
    .video_active (act_a), .frame_start (fs_a)
  );

  vga_char_timing #(
    .H_ACTIVE (HA[1]), .H_FP (HFP[1]), .H_SYNC (HSW[1]), .H_BP (HBP[1]),
    .V_ACTIVE (VA[1]), .V_FP (VFP[1]), .V_SYNC (VSW[1]), .V_BP (VBP[1]),
    .PIPE_LAT (PIPE_LAT), .SYNC_ACTIVE (SPOL[1])
  ) u_dut_b (
    .pixel_clock (pixel_clock), .reset (reset), .disp (bus_b),
    .vga_red (red_b), .vga_green (green_b), .vga_blue (blue_b),
    .vga_hsync (hs_b), .vga_vsync (vs_b),
    .video_active (act_b), .frame_start (fs_b)
  );

  initial pixel_clock = 1'b0;
  always #5 pixel_clock = ~pixel_clock;

  int   total;
  int   bad;
  int   ncyc;
  logic grn;
  logic [1:0] cq_a, rq_a, cq_b, rq_b;

  logic prev_hs_a;
  bit   hs_first;
  int   last_fall;
  logic prev_vs_b;
  int   vs_start;
  int   last_fs;
  int   act_cnt;

  function automatic int h_total(input int m);
    return HA[m] + HFP[m] + HSW[m] + HBP[m];
  endfunction

  function automatic int v_total(input int m);
    return VA[m] + VFP[m] + VSW[m] + VBP[m];
  endfunction

  // Scan position p (pixels since release) expressed as coordinates
  function automatic logic [31:0] exp_coord(input int m, input int p);
    int h, v;
    h = p % h_total(m);
    v = (p / h_total(m)) % v_total(m);
    return {12'd0, 7'(h / 8), 7'(v / 8), 3'(v % 8), 3'(h % 8)};
  endfunction

  // Pins for scan position p; display model returns red = column LSB, blue = row LSB
  function automatic logic [31:0] exp_out(input int m, input int p, input logic g);
    int   h, v;
    logic act, hs, vs, fs;
    h   = p % h_total(m);
    v   = (p / h_total(m)) % v_total(m);
    act = (h < HA[m]) && (v < VA[m]);
    hs  = (h >= HA[m] + HFP[m]) && (h < HA[m] + HFP[m] + HSW[m]);
    vs  = (v >= VA[m] + VFP[m]) && (v < VA[m] + VFP[m] + VSW[m]);
    fs  = (h == 0) && (v == 0);
    return {25'd0, act && ((h / 8) % 2 == 1), act && g, act && ((v / 8) % 2 == 1),
            hs ? SPOL[m] : ~SPOL[m], vs ? SPOL[m] : ~SPOL[m], act, fs};
  endfunction

  function automatic logic [31:0] idle_out(input int m);
    return {25'd0, 3'b000, ~SPOL[m], ~SPOL[m], 2'b00};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, ncyc, got, exp);
    end
  endtask

  task automatic step(input logic rst_v);
    logic g_pre;
    logic [31:0] ea, eb;
    reset = rst_v;
    g_pre = grn;
    @(posedge pixel_clock);
    if (rst_v) ncyc = 0;
    else ncyc = ncyc + 1;
    #1;

    ea = (ncyc == 0) ? 32'd0 : exp_coord(0, ncyc - 1);
    eb = (ncyc == 0) ? 32'd0 : exp_coord(1, ncyc - 1);
    check_val("a_coord", 32'({bus_a.char_column, bus_a.char_line,
                              bus_a.subchar_line, bus_a.subchar_pixel}), ea);
    check_val("b_coord", 32'({bus_b.char_column, bus_b.char_line,
                              bus_b.subchar_line, bus_b.subchar_pixel}), eb);
    ea = (ncyc < LAT) ? idle_out(0) : exp_out(0, ncyc - LAT, g_pre);
    eb = (ncyc < LAT) ? idle_out(1) : exp_out(1, ncyc - LAT, g_pre);
    check_val("a_pins", 32'({red_a, green_a, blue_a, hs_a, vs_a, act_a, fs_a}), ea);
    check_val("b_pins", 32'({red_b, green_b, blue_b, hs_b, vs_b, act_b, fs_b}), eb);

    if (rst_v) begin
      prev_hs_a = 1'b1;
      hs_first  = 1'b1;
      last_fall = -1;
      prev_vs_b = 1'b0;
      vs_start  = -1;
      last_fs   = -1;
      act_cnt   = 0;
    end else begin
      if (prev_hs_a && !hs_a) begin
        if (hs_first) check_val("a_hs_first", 32'(ncyc), 32'(656 + LAT));
        else          check_val("a_hs_period", 32'(ncyc - last_fall), 32'd800);
        hs_first  = 1'b0;
        last_fall = ncyc;
      end else if (!prev_hs_a && hs_a && last_fall >= 0) begin
        check_val("a_hs_width", 32'(ncyc - last_fall), 32'd96);
      end else begin
        prev_hs_a = prev_hs_a;
      end
      prev_hs_a = hs_a;

      if (!prev_vs_b && vs_b) vs_start = ncyc;
      if (prev_vs_b && !vs_b && vs_start >= 0)
        check_val("b_vs_width", 32'(ncyc - vs_start), 32'(VSW[1] * h_total(1)));
      prev_vs_b = vs_b;

      if (fs_b) begin
        if (last_fs >= 0) begin
          check_val("b_fs_period", 32'(ncyc - last_fs), 32'(h_total(1) * v_total(1)));
          check_val("b_act_count", 32'(act_cnt), 32'(HA[1] * VA[1]));
        end
        last_fs = ncyc;
        act_cnt = 0;
      end
      if (act_b) act_cnt = act_cnt + 1;
    end

    // Display model: colour returns PIPE_LAT cycles after its coordinates
    bus_a.vga_red_data  = cq_a[1];
    bus_a.vga_blue_data = rq_a[1];
    bus_b.vga_red_data  = cq_b[1];
    bus_b.vga_blue_data = rq_b[1];
    cq_a = {cq_a[0], bus_a.char_column[0]};
    rq_a = {rq_a[0], bus_a.char_line[0]};
    cq_b = {cq_b[0], bus_b.char_column[0]};
    rq_b = {rq_b[0], bus_b.char_line[0]};
    grn = 1'($urandom_range(0, 1));
    bus_a.vga_green_data = grn;
    bus_b.vga_green_data = grn;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    ncyc  = 0;
    grn   = 1'b0;
    reset = 1'b1;
    cq_a = 2'b00; rq_a = 2'b00; cq_b = 2'b00; rq_b = 2'b00;
    prev_hs_a = 1'b1; hs_first = 1'b1; last_fall = -1;
    prev_vs_b = 1'b0; vs_start = -1; last_fs = -1; act_cnt = 0;
    bus_a.vga_red_data = 1'b1; bus_a.vga_green_data = 1'b0; bus_a.vga_blue_data = 1'b1;
    bus_b.vga_red_data = 1'b1; bus_b.vga_green_data = 1'b0; bus_b.vga_blue_data = 1'b1;

    repeat (5) step(1'b1);
    repeat (40000 + $urandom_range(0, 3000)) step(1'b0);
    step(1'b1);
    repeat (8000) step(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
